// File: rtl/ceyloniac_ctrl_pkg.sv
// rtl/ceyloniac_ctrl_pkg.sv - state encodings, opcodes and mux/ALU codes for the multicycle controller
package ceyloniac_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/ceyloniac_ctrl_next_state.sv
// rtl/ceyloniac_ctrl_next_state.sv - combinational next-state logic of the multicycle controller
module ceyloniac_ctrl_next_state
  import ceyloniac_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6
) (
  input  state_t                  state,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output state_t                  next_state
);

  // Opcode is only looked at in DECODE and MEMADR; memory states wait on mem_ready
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:    next_state = S_FETCH;
      S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OPCODE_WIDTH'(OP_LW) || opcode == OPCODE_WIDTH'(OP_SW))
          next_state = S_MEMADR;
        else if (opcode == OPCODE_WIDTH'(OP_RTYPE))
          next_state = S_EXECUTE;
        else if (opcode == OPCODE_WIDTH'(OP_BEQ))
          next_state = S_BRANCH;
        else if (opcode == OPCODE_WIDTH'(OP_ADDI))
          next_state = S_ADDIEX;
        else if (opcode == OPCODE_WIDTH'(OP_J))
          next_state = S_JUMP;
        else
          next_state = S_ILLEGAL;
      end
      S_MEMADR:  next_state = (opcode == OPCODE_WIDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_ADDIWB:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      S_ILLEGAL: next_state = S_FETCH;
      default:   next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/ceyloniac_multicycle_control_unit.sv
// rtl/ceyloniac_multicycle_control_unit.sv - Moore main controller for the multicycle MIPS-subset core
module ceyloniac_multicycle_control_unit
  import ceyloniac_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_write,
  output logic                    iord,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic                    reg_write,
  output logic                    reg_dst,
  output logic                    mem_to_reg,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_src,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state_dbg
);

  state_t state;
  state_t next_state;

  ceyloniac_ctrl_next_state #(
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_next_state (
    .state      (state),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .next_state (next_state)
  );

  // State register; reset drops straight to IDLE so no write enable survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  assign state_dbg = STATE_WIDTH'(state);

  // Moore decode; only the FETCH IR/PC loads look at mem_ready so they fire once per fetch
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB:  reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ceyloniac_multicycle_control_unit.sv
// tb/tb_ceyloniac_multicycle_control_unit.sv - table-driven bench for the multicycle controller
module tb_ceyloniac_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ceyloniac_multicycle_control_unit #(
    .OPCODE_WIDTH (6),
    .STATE_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  typedef struct {
    logic [5:0]  opcode;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  vec_t vecs[$];

  wire [15:0] act = {mem_req, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  function automatic logic [15:0] ob(input logic req, input logic wr, input logic io,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic rd, input logic m2r, input logic a,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] pcs, input logic ill);
    return {req, wr, io, irw, pcw, rw, rd, m2r, a, b, op, pcs, ill};
  endfunction

  task automatic add(input logic [5:0] op, input logic z, input logic r,
                     input logic [3:0] st, input logic [15:0] o);
    vec_t v;
    v.opcode = op; v.zero = z; v.rdy = r; v.st = st; v.out = o;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
    end
  endtask

  logic [15:0] o_fetch_go, o_fetch_wait, o_decode, o_memadr, o_memrd, o_memwb, o_memwr;
  logic [15:0] o_exec, o_aluwb, o_br_t, o_br_nt, o_addiex, o_addiwb, o_jump, o_ill;

  initial begin
    o_fetch_go   = ob(1,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    o_fetch_wait = ob(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    o_decode     = ob(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    o_memadr     = ob(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    o_memrd      = ob(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    o_memwb      = ob(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    o_memwr      = ob(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    o_exec       = ob(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
    o_aluwb      = ob(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0);
    o_br_t       = ob(0,0,0,0,1,0,0,0,1,2'b00,2'b01,2'b01,0);
    o_br_nt      = ob(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    o_addiex     = ob(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    o_addiwb     = ob(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0);
    o_jump       = ob(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b10,0);
    o_ill        = ob(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);

    // LW, memory always ready
    add(6'b100011, 0, 1, 4'd1, o_fetch_go);
    add(6'b100011, 0, 1, 4'd2, o_decode);
    add(6'b100011, 0, 1, 4'd3, o_memadr);
    add(6'b100011, 0, 1, 4'd4, o_memrd);
    add(6'b100011, 0, 1, 4'd5, o_memwb);
    // FETCH stalled three cycles, then R-type
    add(6'b000000, 0, 0, 4'd1, o_fetch_wait);
    add(6'b000000, 0, 0, 4'd1, o_fetch_wait);
    add(6'b000000, 0, 0, 4'd1, o_fetch_wait);
    add(6'b000000, 0, 1, 4'd1, o_fetch_go);
    add(6'b000000, 0, 1, 4'd2, o_decode);
    add(6'b000000, 0, 1, 4'd7, o_exec);
    add(6'b000000, 0, 1, 4'd8, o_aluwb);
    // BEQ taken
    add(6'b000100, 1, 1, 4'd1, o_fetch_go);
    add(6'b000100, 1, 1, 4'd2, o_decode);
    add(6'b000100, 1, 1, 4'd9, o_br_t);
    // BEQ not taken
    add(6'b000100, 0, 1, 4'd1, o_fetch_go);
    add(6'b000100, 0, 1, 4'd2, o_decode);
    add(6'b000100, 0, 1, 4'd9, o_br_nt);
    // undefined opcode: one ILLEGAL cycle then FETCH
    add(6'b111111, 0, 1, 4'd1, o_fetch_go);
    add(6'b111111, 0, 1, 4'd2, o_decode);
    add(6'b111111, 0, 1, 4'd13, o_ill);
    // SW with two wait cycles in MEMWR
    add(6'b101011, 0, 1, 4'd1, o_fetch_go);
    add(6'b101011, 0, 1, 4'd2, o_decode);
    add(6'b101011, 0, 1, 4'd3, o_memadr);
    add(6'b101011, 0, 0, 4'd6, o_memwr);
    add(6'b101011, 0, 0, 4'd6, o_memwr);
    add(6'b101011, 0, 1, 4'd6, o_memwr);
    // ADDI
    add(6'b001000, 0, 1, 4'd1, o_fetch_go);
    add(6'b001000, 0, 1, 4'd2, o_decode);
    add(6'b001000, 0, 1, 4'd10, o_addiex);
    add(6'b001000, 0, 1, 4'd11, o_addiwb);
    // J
    add(6'b000010, 0, 1, 4'd1, o_fetch_go);
    add(6'b000010, 0, 1, 4'd2, o_decode);
    add(6'b000010, 0, 1, 4'd12, o_jump);
    // R-type that will be cut off by reset in EXECUTE
    add(6'b000000, 0, 1, 4'd1, o_fetch_go);
    add(6'b000000, 0, 1, 4'd2, o_decode);
    add(6'b000000, 0, 1, 4'd7, o_exec);

    rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset_state", 0, {12'b0, state_dbg}, 16'd0);
    check("reset_outputs", 0, act, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_before_edge", 0, {12'b0, state_dbg}, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      opcode    = vecs[i].opcode;
      zero      = vecs[i].zero;
      mem_ready = vecs[i].rdy;
      #1;
      check("state", i, {12'b0, state_dbg}, {12'b0, vecs[i].st});
      check("outputs", i, act, vecs[i].out);
    end

    // asynchronous reset while in EXECUTE, no clock edge involved
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 100, {12'b0, state_dbg}, 16'd0);
    check("async_rst_outputs", 100, act, 16'd0);
    @(posedge clk);
    #1;
    check("held_rst_state", 101, {12'b0, state_dbg}, 16'd0);
    check("held_rst_outputs", 101, act, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_state", 102, {12'b0, state_dbg}, 16'd1);
    check("post_rst_outputs", 102, act, o_fetch_go);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
